// File: rtl/mdl_relpg_seq.sv
// Relative-page sequencer: 20-step timing ring, add-frame request FSM and
// serial capture of the relative page counter value.
module mdl_relpg_seq (
  input  logic        i_MCLK,
  input  logic        i_RST_n,
  input  logic        i_CLK2M_PCEN_n,
  input  logic        i_REQ,
  input  logic [11:0] i_REQ_CNT,
  input  logic        i_ABORT,
  input  logic        i_RELPGCNTR_LSB,
  output logic [19:0] o_ROT20_n,
  output logic        o_CNT_START,
  output logic        o_CNT_STOP,
  output logic        o_ACK,
  output logic        o_BUSY,
  output logic [11:0] o_PAGE,
  output logic        o_PAGE_VLD
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [19:0] r_ring;
  logic [11:0] r_remaining;
  logic [11:0] w_remNext;
  logic [11:0] r_shadow;
  logic [11:0] r_page;
  logic        r_pageVld;
  logic        r_start;
  logic        r_stop;
  logic        r_ack;
  logic        r_busy;
  logic        w_startNext;
  logic        w_stopNext;
  logic        w_tick;
  logic        w_step18;
  logic        w_step12;
  logic        w_capStep;

  assign w_tick    = ~i_CLK2M_PCEN_n;
  assign w_step18  = ~r_ring[18];
  assign w_step12  = ~r_ring[12];
  // Steps 0..11 are the serial capture window.
  assign w_capStep = ~(&r_ring[11:0]);

  always_comb begin
    w_stateNext = r_state;
    w_remNext   = r_remaining;
    w_startNext = 1'b0;
    w_stopNext  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_REQ) begin
          if (i_REQ_CNT != 12'd0) begin
            w_remNext   = i_REQ_CNT;
            w_stateNext = ARM;
          end else begin
            w_stateNext = DONE;
          end
        end
      end
      ARM: begin
        // Abort wins over a START that would be issued on the same tick.
        if (i_ABORT) begin
          w_stateNext = DONE;
        end else if (w_step18) begin
          w_startNext = 1'b1;
          w_stateNext = RUN;
        end
      end
      RUN: begin
        if (w_step18) begin
          if ((r_remaining == 12'd1) || i_ABORT) begin
            w_stopNext  = 1'b1;
            w_stateNext = DONE;
          end else begin
            w_remNext = r_remaining - 12'd1;
          end
        end else if (i_ABORT) begin
          w_remNext = 12'd1;
        end
      end
      DONE: begin
        if (!i_REQ) begin
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_ring      <= 20'hFFFFE;
      r_state     <= IDLE;
      r_remaining <= 12'd0;
      r_shadow    <= 12'd0;
      r_page      <= 12'd0;
      r_pageVld   <= 1'b0;
      r_start     <= 1'b0;
      r_stop      <= 1'b0;
      r_ack       <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_tick) begin
      r_ring      <= {r_ring[18:0], r_ring[19]};
      r_state     <= w_stateNext;
      r_remaining <= w_remNext;
      r_start     <= w_startNext;
      r_stop      <= w_stopNext;
      r_ack       <= (w_stateNext == DONE);
      r_busy      <= (w_stateNext == ARM) || (w_stateNext == RUN);
      if (w_capStep) begin
        r_shadow <= {i_RELPGCNTR_LSB, r_shadow[11:1]};
      end
      if (w_step12) begin
        r_page    <= r_shadow;
        r_pageVld <= 1'b1;
      end
    end
  end

  assign o_ROT20_n   = r_ring;
  assign o_CNT_START = r_start;
  assign o_CNT_STOP  = r_stop;
  assign o_ACK       = r_ack;
  assign o_BUSY      = r_busy;
  assign o_PAGE      = r_page;
  assign o_PAGE_VLD  = r_pageVld;

endmodule
